// File: rtl/l2_mem_master_pkg.sv
// Shared state type, error response word and address helper for the L2 bank master.
package l2_mem_master_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        RUN  = 2'd2
    } state_e;

    localparam logic [31:0] ERR_RDATA = 32'hBADA_CCE5;

    // Full-width word address, so callers can range-check the upper bits as well.
    function automatic logic [31:0] word_addr(input logic [31:0] byte_addr);
        return byte_addr >> 2;
    endfunction

endpackage

// File: rtl/l2_mem_bus_master_if.sv
// Upstream word-access bus: req/gnt request phase plus a one-cycle r_valid response phase.
interface l2_mem_bus_master_if;

    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        r_valid;
    logic [31:0] r_rdata;
    logic        r_err;

    modport master (
        output req, we, be, addr, wdata,
        input  gnt, r_valid, r_rdata, r_err
    );

    modport slave (
        input  req, we, be, addr, wdata,
        output gnt, r_valid, r_rdata, r_err
    );

endinterface

// File: rtl/l2_mem_init_seq.sv
// Fill-sweep word counter with a sticky done flag, used by the bank master after boot.
module l2_mem_init_seq #(
    parameter int unsigned ADDR_WIDTH = 15,
    parameter int unsigned BANK_WORDS = 29184
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  i_clear,
    input  logic                  i_step,
    output logic [ADDR_WIDTH-1:0] o_count,
    output logic                  o_last,
    output logic                  o_done
);

    localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(BANK_WORDS - 1);

    logic [ADDR_WIDTH-1:0] r_count;
    logic                  r_done;
    logic                  w_last;

    assign w_last = (r_count == LAST_WORD);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_count <= '0;
            r_done  <= 1'b0;
        end else begin
            if (i_clear) begin
                r_count <= '0;
            end else if (i_step) begin
                r_count <= r_count + ADDR_WIDTH'(1);
            end
            // Sticky until reset: only one sweep per reset.
            if (i_step && w_last) begin
                r_done <= 1'b1;
            end
        end
    end

    assign o_count = r_count;
    assign o_last  = w_last;
    assign o_done  = r_done;

endmodule

// File: rtl/l2_mem_bus_master.sv
// Upstream req/gnt to single-port SRAM bank bridge with address range checking.
// Optional post-boot fill sweep enabled by defining L2_MEM_MASTER_INIT_EN.
module l2_mem_bus_master
    import l2_mem_master_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 15,
    parameter int unsigned BANK_WORDS   = 29184,
    parameter logic [31:0] INIT_PATTERN = 32'h0000_0000
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_init_i,
    output logic                  init_done_o,
    l2_mem_bus_master_if.slave    bus,
    output logic                  mem_csn_o,
    output logic                  mem_wen_o,
    output logic [3:0]            mem_be_o,
    output logic [ADDR_WIDTH-1:0] mem_add_o,
    output logic [31:0]           mem_wdata_o,
    input  logic [31:0]           mem_rdata_i
);

    logic [31:0]           w_word;
    logic                  w_in_range;
    logic                  w_gnt;
    logic                  w_acc;
    logic                  w_run;
    logic                  w_init_act;
    logic [ADDR_WIDTH-1:0] w_init_add;

    logic r_rsp_valid;
    logic r_rsp_err;
    logic r_rsp_read;

    assign w_word     = word_addr(bus.addr);
    assign w_in_range = ((w_word >> ADDR_WIDTH) == 32'd0) && (w_word < BANK_WORDS);
    assign w_gnt      = w_run & bus.req;
    assign w_acc      = w_gnt & w_in_range;

`ifdef L2_MEM_MASTER_INIT_EN
    state_e r_state;
    state_e w_state_next;
    logic   w_init_clear;
    logic   w_init_last;
    logic   w_init_done;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (start_init_i) w_state_next = INIT;
            INIT:    if (w_init_last) w_state_next = RUN;
            RUN:     w_state_next = RUN;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_run        = (r_state == RUN);
        w_init_act   = (r_state == INIT);
        w_init_clear = (r_state == IDLE) && start_init_i;
    end

    l2_mem_init_seq #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .BANK_WORDS (BANK_WORDS)
    ) u_init_seq (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_clear (w_init_clear),
        .i_step  (w_init_act),
        .o_count (w_init_add),
        .o_last  (w_init_last),
        .o_done  (w_init_done)
    );

    assign init_done_o = w_init_done;
`else
    logic w_unused_start;

    assign w_run          = 1'b1;
    assign w_init_act     = 1'b0;
    assign w_init_add     = '0;
    assign init_done_o    = 1'b1;
    assign w_unused_start = start_init_i;
`endif

    // Sweep owns the bank while active; out-of-range requests never strobe it.
    always_comb begin
        mem_csn_o   = 1'b1;
        mem_wen_o   = 1'b1;
        mem_be_o    = 4'h0;
        mem_add_o   = '0;
        mem_wdata_o = 32'h0;
        if (w_init_act) begin
            mem_csn_o   = 1'b0;
            mem_wen_o   = 1'b0;
            mem_be_o    = 4'hF;
            mem_add_o   = w_init_add;
            mem_wdata_o = INIT_PATTERN;
        end else if (w_acc) begin
            mem_csn_o   = 1'b0;
            mem_wen_o   = ~bus.we;
            mem_be_o    = bus.be;
            mem_add_o   = w_word[ADDR_WIDTH-1:0];
            mem_wdata_o = bus.wdata;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_read  <= 1'b0;
        end else begin
            r_rsp_valid <= w_gnt;
            r_rsp_err   <= w_gnt & ~w_in_range;
            r_rsp_read  <= w_acc & ~bus.we;
        end
    end

    assign bus.gnt     = w_gnt;
    assign bus.r_valid = r_rsp_valid;
    assign bus.r_err   = r_rsp_err;
    // Bank read data arrives the cycle after the strobe, aligned with the response.
    assign bus.r_rdata = r_rsp_err ? ERR_RDATA : (r_rsp_read ? mem_rdata_i : 32'h0);

endmodule
